// File: rtl/tmds_channel_decoder.sv
// TMDS receive lane: finds 10b symbol alignment from control-token runs,
// then decodes each aligned symbol to a data byte or a 2-bit control code.
module tmds_channel_decoder #(
    parameter int unsigned SEARCH_CYCLES = 2048,
    parameter int unsigned LOCK_TOKENS   = 16,
    parameter int unsigned LOSS_CYCLES   = 4096
) (
    input  logic       i_pix_clk,
    input  logic       i_rst_n,
    input  logic [9:0] i_tmds_word,
    input  logic       i_realign,
    output logic [7:0] o_data,
    output logic [1:0] o_ctrl,
    output logic       o_de,
    output logic       o_locked,
    output logic [3:0] o_offset
);

    localparam int unsigned SCW = $clog2(SEARCH_CYCLES + 1);
    localparam int unsigned TCW = $clog2(LOCK_TOKENS + 1);
    localparam int unsigned LCW = $clog2(LOSS_CYCLES + 1);

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e           state_q,  state_d;
    logic [9:0]       prev_q;
    logic [9:0]       win_q,    win_d;
    logic             skip_q,   skip_d;
    logic [3:0]       offset_q, offset_d;
    logic [SCW-1:0]   search_q, search_d;
    logic [TCW-1:0]   tok_q,    tok_d;
    logic [LCW-1:0]   loss_q,   loss_d;
    logic             locked_q, locked_d;
    logic [7:0]       data_q,   data_d;
    logic [1:0]       ctrl_q,   ctrl_d;
    logic             de_q,     de_d;

    logic             is_tok_c;
    logic [1:0]       tok_bits_c;
    logic             tok_seen_c;
    logic [3:0]       next_off_c;
    logic [7:0]       q_c;
    logic [7:0]       dec_c;

    // Window at the current bit offset; older word sits in the low half.
    assign win_d = 10'({i_tmds_word, prev_q} >> offset_q);

    always_comb begin
        is_tok_c   = 1'b1;
        tok_bits_c = 2'b00;
        case (win_q)
            TOK_00:  tok_bits_c = 2'b00;
            TOK_01:  tok_bits_c = 2'b01;
            TOK_10:  tok_bits_c = 2'b10;
            TOK_11:  tok_bits_c = 2'b11;
            default: is_tok_c   = 1'b0;
        endcase
    end

    // Undo the DC-balance inversion, then the XOR/XNOR transition coding.
    always_comb begin
        q_c      = win_q[9] ? ~win_q[7:0] : win_q[7:0];
        dec_c    = '0;
        dec_c[0] = q_c[0];
        for (int i = 1; i < 8; i++) begin
            dec_c[i] = win_q[8] ? (q_c[i] ^ q_c[i-1]) : ~(q_c[i] ^ q_c[i-1]);
        end
    end

    // The window right after an offset change was formed at the old offset.
    assign tok_seen_c = is_tok_c && !skip_q;
    assign next_off_c = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        search_d = search_q;
        tok_d    = tok_q;
        loss_d   = loss_q;
        locked_d = locked_q;

        case (state_q)
            ST_SEARCH: begin
                if (tok_seen_c) begin
                    state_d  = ST_VERIFY;
                    tok_d    = TCW'(1);
                    search_d = '0;
                end else if (search_q >= SCW'(SEARCH_CYCLES - 1)) begin
                    offset_d = next_off_c;
                    search_d = '0;
                end else begin
                    search_d = search_q + SCW'(1);
                end
            end
            ST_VERIFY: begin
                if (skip_q) begin
                    state_d = state_q;
                end else if (tok_seen_c) begin
                    if (tok_q >= TCW'(LOCK_TOKENS - 1)) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                        tok_d    = TCW'(LOCK_TOKENS);
                        loss_d   = '0;
                    end else begin
                        tok_d = tok_q + TCW'(1);
                    end
                end else begin
                    state_d  = ST_SEARCH;
                    offset_d = next_off_c;
                    tok_d    = '0;
                    search_d = '0;
                end
            end
            ST_LOCKED: begin
                if (tok_seen_c) begin
                    tok_d = (tok_q >= TCW'(LOCK_TOKENS)) ? tok_q : tok_q + TCW'(1);
                end else begin
                    tok_d = '0;
                end
                if (tok_seen_c && (tok_q >= TCW'(LOCK_TOKENS - 1))) begin
                    loss_d = '0;
                end else if (loss_q >= LCW'(LOSS_CYCLES - 1)) begin
                    state_d  = ST_SEARCH;
                    locked_d = 1'b0;
                    loss_d   = '0;
                    tok_d    = '0;
                    search_d = '0;
                end else begin
                    loss_d = loss_q + LCW'(1);
                end
            end
            default: begin
                state_d  = ST_SEARCH;
                locked_d = 1'b0;
            end
        endcase

        if (i_realign) begin
            state_d  = ST_SEARCH;
            offset_d = next_off_c;
            locked_d = 1'b0;
            search_d = '0;
            tok_d    = '0;
            loss_d   = '0;
        end
    end

    assign skip_d = (offset_d != offset_q);

    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        de_d   = 1'b0;
        if (is_tok_c) begin
            ctrl_d = tok_bits_c;
        end else begin
            data_d = dec_c;
            de_d   = locked_d;
        end
    end

    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_SEARCH;
            prev_q   <= '0;
            win_q    <= '0;
            skip_q   <= 1'b0;
            offset_q <= '0;
            search_q <= '0;
            tok_q    <= '0;
            loss_q   <= '0;
            locked_q <= 1'b0;
            data_q   <= '0;
            ctrl_q   <= '0;
            de_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= i_tmds_word;
            win_q    <= win_d;
            skip_q   <= skip_d;
            offset_q <= offset_d;
            search_q <= search_d;
            tok_q    <= tok_d;
            loss_q   <= loss_d;
            locked_q <= locked_d;
            data_q   <= data_d;
            ctrl_q   <= ctrl_d;
            de_q     <= de_d;
        end
    end

    assign o_data   = data_q;
    assign o_ctrl   = ctrl_q;
    assign o_de     = de_q;
    assign o_locked = locked_q;
    assign o_offset = offset_q;

endmodule
